// File: rtl/disp_pkg.sv
// Shared constants for the 7-segment scan driver: page codes and active-low patterns.
// Pure definitions, no latency; no flow control involved.
// Patterns are {g,f,e,d,c,b,a}, a lit segment is 0.
package disp_pkg;

  typedef enum logic [1:0] {
    PAGE_SEC  = 2'd0,
    PAGE_HM   = 2'd1,
    PAGE_DATE = 2'd2,
    PAGE_YEAR = 2'd3
  } page_t;

  localparam logic [6:0] SEG_OFF   = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [3:0] ANODE_OFF = 4'hF;

  // Entry n is the pattern for digit n (entry 0 in the low bits).
  localparam logic [9:0][6:0] DIGIT_PAT = {
    7'h10, 7'h00, 7'h78, 7'h02, 7'h12,
    7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

endpackage

// File: rtl/display_scan_bcd_to_seg7.sv
// BCD nibble to active-low 7-segment pattern; codes 10-15 show a dash.
// Combinational, zero latency; no flow control.
// Always ready: output follows the input nibble.
module bcd_to_seg7
  import disp_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_DASH;
    if (nib < 4'd10) seg = DIGIT_PAT[nib];
  end

endmodule

// File: rtl/display_scan.sv
// Time-multiplexed 4-digit 7-segment driver for the time/date BCD buses (LEADING_ZERO_BLANK_EN option).
// Outputs registered: one cycle from presc/digit/page_q/inputs to pins.
// No backpressure: buses are sampled live every cycle; page changes apply at frame boundaries.
module display_scan
  import disp_pkg::*;
#(
  parameter int DIGIT_TICKS = 50000,
  parameter int BLANK_TICKS = 500
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  decimales,
  input  logic [6:0]  segundos,
  input  logic [6:0]  minutos,
  input  logic [5:0]  horas,
  input  logic [5:0]  dias,
  input  logic [4:0]  meses,
  input  logic [15:0] years,
  input  logic [1:0]  page,
  output logic [3:0]  Trans,
  output logic [6:0]  seg,
  output logic        dp
);

  localparam int PW = (DIGIT_TICKS > 1) ? $clog2(DIGIT_TICKS) : 1;

  logic [PW-1:0] presc;
  logic [1:0]    digit;
  page_t         page_q;
  logic          slot_end;
  logic [15:0]   word;
  logic [3:0]    nib;
  logic [6:0]    seg_dec;
  logic          blank;
  logic          dark;

  assign slot_end = (presc == PW'(DIGIT_TICKS - 1));

  always_ff @(posedge clk) begin
    if (!reset) begin
      presc  <= '0;
      digit  <= 2'd0;
      page_q <= PAGE_SEC;
    end else if (slot_end) begin
      presc <= '0;
      digit <= digit + 2'd1;
      // The page only changes between frames so a frame never mixes two pages.
      if (digit == 2'd3) page_q <= page_t'(page);
    end else begin
      presc <= presc + PW'(1);
    end
  end

  always_comb begin
    word = 16'h0000;
    case (page_q)
      PAGE_SEC:  word = {1'b0, segundos, decimales};
      PAGE_HM:   word = {2'b00, horas, 1'b0, minutos};
      PAGE_DATE: word = {3'b000, meses, 2'b00, dias};
      PAGE_YEAR: word = years;
      default:   word = 16'h0000;
    endcase
  end

  assign nib = word[{digit, 2'b00} +: 4];

  bcd_to_seg7 u_dec (
    .nib (nib),
    .seg (seg_dec)
  );

  assign blank = (presc < PW'(BLANK_TICKS));

`ifdef LEADING_ZERO_BLANK_EN
  // A year digit is dark when it and every digit to its left are zero.
  assign dark = ((page_q == PAGE_YEAR) && (digit != 2'd0) && ((years >> {digit, 2'b00}) == 16'h0000))
             || ((page_q == PAGE_HM) && (digit == 2'd3) && (horas[5:4] == 2'b00));
`else
  assign dark = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      Trans <= ANODE_OFF;
      seg   <= SEG_OFF;
      dp    <= 1'b1;
    end else if (blank || dark) begin
      Trans <= ANODE_OFF;
      seg   <= SEG_OFF;
      dp    <= 1'b1;
    end else begin
      Trans <= ~(4'b0001 << digit);
      seg   <= seg_dec;
      dp    <= !((digit == 2'd2) && (page_q != PAGE_YEAR));
    end
  end

endmodule
